// File: rtl/mul_acc_pkg.sv
// Shared types, default widths and the magnitude helper for the mul_acc
// iterative signed multiply-accumulate unit.
package mul_acc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int unsigned MCAND_W_DEF  = 64;
   localparam int unsigned MPLIER_W_DEF = 32;
   localparam int unsigned ADDEND_W_DEF = 32;
   localparam int unsigned ABS_MAX_W    = 128;

   // Callers sign-extend into ABS_MAX_W bits and keep only the low bits they need.
   function automatic logic [ABS_MAX_W-1:0] abs_mag(input logic [ABS_MAX_W-1:0] v);
      logic [ABS_MAX_W-1:0] mag;
      if (v[ABS_MAX_W-1]) begin
         mag = ~v + ABS_MAX_W'(1'b1);
      end else begin
         mag = v;
      end
      return mag;
   endfunction

endpackage

// File: rtl/mul_acc.sv
// Radix-2 shift-add signed multiply-accumulate: result = multiplicand * multiplier + addend.
// Optional macro MUL_ACC_EARLY_EXIT_EN leaves CALC as soon as the remaining multiplier is zero.
module mul_acc
   import mul_acc_pkg::*;
#(
   parameter int MCAND_WIDTH  = MCAND_W_DEF,
   parameter int MPLIER_WIDTH = MPLIER_W_DEF,
   parameter int ADDEND_WIDTH = ADDEND_W_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    valid_in,
   input  logic [MCAND_WIDTH-1:0]  multiplicand,
   input  logic [MPLIER_WIDTH-1:0] multiplier,
   input  logic [ADDEND_WIDTH-1:0] addend,
   output logic                    busy,
   output logic [MCAND_WIDTH-1:0]  result,
   output logic                    overflow,
   output logic                    valid_out
);

   localparam int ACC_W  = MCAND_WIDTH + MPLIER_WIDTH;
   localparam int FULL_W = ACC_W + 1;
   localparam int CNT_W  = $clog2(MPLIER_WIDTH + 1);

   state_t                  state_q;
   logic [ACC_W-1:0]        mcand_q;
   logic [MPLIER_WIDTH-1:0] mplier_q;
   logic [ACC_W-1:0]        acc_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    sign_q;
   logic [ADDEND_WIDTH-1:0] addend_q;
   logic [MCAND_WIDTH-1:0]  result_q;
   logic                    overflow_q;
   logic                    valid_out_q;

   logic [ABS_MAX_W-1:0]    mcand_abs_s;
   logic [ABS_MAX_W-1:0]    mplier_abs_s;
   logic [ACC_W-1:0]        acc_add_s;
   logic [FULL_W-1:0]       prod_s;
   logic [FULL_W-1:0]       full_d;
   logic                    overflow_d;
   logic                    calc_exit_s;
   logic                    unused_abs_s;

   // Operand magnitudes, the single datapath adder and the final signed fix-up.
   always_comb begin
      mcand_abs_s  = abs_mag({{(ABS_MAX_W-MCAND_WIDTH){multiplicand[MCAND_WIDTH-1]}}, multiplicand});
      mplier_abs_s = abs_mag({{(ABS_MAX_W-MPLIER_WIDTH){multiplier[MPLIER_WIDTH-1]}}, multiplier});
      unused_abs_s = ^{mcand_abs_s[ABS_MAX_W-1:MCAND_WIDTH], mplier_abs_s[ABS_MAX_W-1:MPLIER_WIDTH]};

      if (mplier_q[0]) begin
         acc_add_s = acc_q + mcand_q;
      end else begin
         acc_add_s = acc_q;
      end

      prod_s = {1'b0, acc_q};
      if (sign_q) begin
         prod_s = ~prod_s + FULL_W'(1'b1);
      end else begin
         prod_s = {1'b0, acc_q};
      end

      full_d     = prod_s + {{(FULL_W-ADDEND_WIDTH){addend_q[ADDEND_WIDTH-1]}}, addend_q};
      // Representable only if every bit above the result is a copy of its sign bit.
      overflow_d = (full_d != {{(FULL_W-MCAND_WIDTH){full_d[MCAND_WIDTH-1]}}, full_d[MCAND_WIDTH-1:0]});

`ifdef MUL_ACC_EARLY_EXIT_EN
      calc_exit_s = (cnt_q == CNT_W'(MPLIER_WIDTH-1)) || (mplier_q == '0);
`else
      calc_exit_s = (cnt_q == CNT_W'(MPLIER_WIDTH-1));
`endif
   end

   // Control FSM with the iteration registers and the registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         sign_q      <= 1'b0;
         addend_q    <= '0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
         valid_out_q <= 1'b0;
      end else begin
         valid_out_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (valid_in) begin
                  mcand_q  <= {{MPLIER_WIDTH{1'b0}}, mcand_abs_s[MCAND_WIDTH-1:0]};
                  mplier_q <= mplier_abs_s[MPLIER_WIDTH-1:0];
                  sign_q   <= multiplicand[MCAND_WIDTH-1] ^ multiplier[MPLIER_WIDTH-1];
                  addend_q <= addend;
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= CALC;
               end else begin
                  state_q  <= IDLE;
               end
            end
            CALC: begin
               acc_q    <= acc_add_s;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + CNT_W'(1'b1);
               if (calc_exit_s) begin
                  state_q <= FINISH;
               end else begin
                  state_q <= CALC;
               end
            end
            FINISH: begin
               result_q   <= full_d[MCAND_WIDTH-1:0];
               overflow_q <= overflow_d;
               state_q    <= DONE;
            end
            DONE: begin
               valid_out_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign result    = result_q;
   assign overflow  = overflow_q;
   assign valid_out = valid_out_q;

endmodule

// File: tb/tb_mul_acc.sv
// Directed scoreboard bench for mul_acc: expectations are queued at acceptance
// and compared when valid_out pulses.
module tb_mul_acc;

   typedef struct packed {
      logic [63:0] res;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [63:0] multiplicand;
   logic [31:0] multiplier;
   logic [31:0] addend;
   logic        busy;
   logic [63:0] result;
   logic        overflow;
   logic        valid_out;

   int   tests;
   int   fails;
   exp_t sb_q[$];

   mul_acc dut (
      .clk          (clk),
      .reset        (reset),
      .valid_in     (valid_in),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .busy         (busy),
      .result       (result),
      .overflow     (overflow),
      .valid_out    (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic signed [63:0] mc, input logic signed [31:0] mp,
                                  input logic signed [31:0] ad);
      logic signed [127:0] full;
      exp_t e;
      full  = mc * mp + ad;
      e.res = full[63:0];
      e.ovf = (full != {{64{full[63]}}, full[63:0]});
      return e;
   endfunction

   function automatic int exp_lat(input logic [31:0] mp);
      int lat;
      lat = 34;
`ifdef MUL_ACC_EARLY_EXIT_EN
      begin
         logic [31:0] mag;
         mag = mp[31] ? (~mp + 32'd1) : mp;
         lat = 3;
         for (int i = 0; i < 32; i++) begin
            if (mag[i]) lat = i + 4;
         end
         if (lat > 34) lat = 34;
      end
`endif
      return lat;
   endfunction

   task automatic push_exp(input logic [63:0] res, input logic ovf);
      exp_t e;
      e.res = res;
      e.ovf = ovf;
      sb_q.push_back(e);
   endtask

   task automatic start_op(input logic [63:0] mc, input logic [31:0] mp, input logic [31:0] ad);
      multiplicand = mc;
      multiplier   = mp;
      addend       = ad;
      valid_in     = 1'b1;
      @(posedge clk);
      #1;
      valid_in     = 1'b0;
      multiplicand = {$urandom, $urandom};
      multiplier   = $urandom;
      addend       = $urandom;
      check("accept_busy", {63'd0, busy}, 64'd1);
   endtask

   task automatic wait_result(input string tag, input int lat);
      int   n;
      int   busy_cnt;
      bit   got;
      exp_t e;
      n = 0;
      busy_cnt = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (valid_out) got = 1'b1;
         else if (busy) busy_cnt++;
      end
      check({tag, "_timeout"}, {63'd0, got}, 64'd1);
      if (got) begin
         check({tag, "_latency"}, 64'(n), 64'(lat));
         check({tag, "_busy_cycles"}, 64'(busy_cnt + 1), 64'(lat));
         check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_overflow"}, {63'd0, overflow}, {63'd0, e.ovf});
         end
      end
   endtask

   task automatic no_valid(input string tag, input int cycles);
      int c;
      c = 0;
      repeat (cycles) begin
         @(posedge clk);
         #1;
         if (valid_out) c++;
      end
      check(tag, 64'(c), 64'd0);
   endtask

   initial begin
      tests        = 0;
      fails        = 0;
      reset        = 1'b1;
      valid_in     = 1'b0;
      multiplicand = 64'd0;
      multiplier   = 32'd0;
      addend       = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_result", result, 64'd0);
      check("rst_overflow", {63'd0, overflow}, 64'd0);
      check("rst_valid", {63'd0, valid_out}, 64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      start_op(64'd7, -32'sd3, 32'd2);
      push_exp(-64'sd19, 1'b0);
      wait_result("basic", 34);

      start_op(-64'sd5, -32'sd4, -32'sd1);
      push_exp(64'd19, 1'b0);
      wait_result("roundtrip", 34);

      start_op(64'h4000_0000_0000_0000, 32'd4, 32'd0);
      push_exp(64'd0, 1'b1);
      wait_result("pos_ovf", 34);

      start_op(64'h8000_0000_0000_0000, 32'd1, 32'd0);
      push_exp(64'h8000_0000_0000_0000, 1'b0);
      wait_result("min_x1", exp_lat(32'd1));

      start_op(64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 32'd0);
      push_exp(64'h8000_0000_0000_0000, 1'b1);
      wait_result("min_xm1", exp_lat(32'hFFFF_FFFF));

      start_op(64'd12345, 32'd0, -32'sd9);
      push_exp(-64'sd9, 1'b0);
      wait_result("zero_mplier", exp_lat(32'd0));

      // A strobe while busy must be dropped, not queued.
      start_op(64'd100, 32'd3, 32'd0);
      push_exp(64'd300, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      multiplicand = 64'd7;
      multiplier   = 32'd7;
      addend       = 32'd7;
      valid_in     = 1'b1;
      @(posedge clk);
      #1;
      valid_in     = 1'b0;
      wait_result("busy_ignore", exp_lat(32'd3) - 6);
      no_valid("busy_ignore_extra_valid", 40);

      // A strobe in the DONE cycle must also be dropped.
      start_op(64'd21, 32'd2, 32'd1);
      push_exp(64'd43, 1'b0);
      repeat (exp_lat(32'd2) - 1) @(posedge clk);
      #1;
      check("done_busy", {63'd0, busy}, 64'd1);
      valid_in = 1'b1;
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      check("done_valid", {63'd0, valid_out}, 64'd1);
      check("done_idle", {63'd0, busy}, 64'd0);
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         check("done_result", result, e.res);
      end
      no_valid("done_ignore_extra_valid", 40);

      for (int i = 0; i < 6; i++) begin
         logic [63:0] mc;
         logic [31:0] mp;
         logic [31:0] ad;
         exp_t        e;
         mc = {$urandom, $urandom};
         mp = (i < 3) ? $urandom : $urandom_range(0, 255);
         ad = $urandom;
         e  = model(mc, mp, ad);
         start_op(mc, mp, ad);
         sb_q.push_back(e);
         wait_result("random", exp_lat(mp));
      end

      // Reset in the middle of CALC discards the operation.
      start_op(64'd5, 32'd5, 32'd5);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_result", result, 64'd0);
      check("midrst_overflow", {63'd0, overflow}, 64'd0);
      check("midrst_valid", {63'd0, valid_out}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      no_valid("midrst_no_valid", 40);

      start_op(64'd1, 32'd1, 32'd1);
      push_exp(64'd2, 1'b0);
      wait_result("after_rst", exp_lat(32'd1));

      check("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mul_acc.md
Name: mul_acc

Overview:
- Iterative signed multiply-accumulate: result = multiplicand * multiplier + addend.
- It is the inverse of the iterative divider. It rebuilds dividend = quotient * divisor + remainder.
- Used by the FM datapath for fixed-point gain and scaling, and as an on-chip checker for divider results.
- Radix-2 shift-add, one multiplier bit per cycle, with a valid_in / valid_out pulse handshake.

Parameters:
- MCAND_WIDTH, 64, multiplicand (quotient-side) width; the result has the same width.
- MPLIER_WIDTH, 32, multiplier (divisor-side) width; this is also the iteration count.
- ADDEND_WIDTH, 32, addend (remainder-side) width; sign-extended before the add.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- valid_in  input  1  operand strobe; sampled only in IDLE
- multiplicand  input  MCAND_WIDTH  signed two's complement
- multiplier  input  MPLIER_WIDTH  signed two's complement
- addend  input  ADDEND_WIDTH  signed two's complement
- busy  output  1  high in every state other than IDLE
- result  output  MCAND_WIDTH  low MCAND_WIDTH bits of the exact signed result; registered
- overflow  output  1  exact result is not representable in MCAND_WIDTH signed; registered
- valid_out  output  1  one-cycle pulse when result and overflow update

Behaviour:
- Reset (asynchronous, any state): state goes to IDLE. result, overflow, valid_out, busy and all internal registers go to 0. An operation in flight is discarded and produces no valid_out.
- States: IDLE, CALC, FINISH, DONE.
- IDLE:
  - On a clock edge with valid_in=1, latch all three operands.
  - Latch |multiplicand| as an unsigned MCAND_WIDTH-bit value; -2^(MCAND_WIDTH-1) is valid.
  - Latch |multiplier| as an unsigned MPLIER_WIDTH-bit value.
  - Latch the product sign = sign(multiplicand) XOR sign(multiplier).
  - Clear the MCAND_WIDTH+MPLIER_WIDTH-bit accumulator and the iteration counter.
  - Go to CALC.
- CALC:
  - Each cycle: if the multiplier LSB is 1, add the shifted multiplicand to the accumulator.
  - Then shift the multiplicand left, shift the multiplier right, and increment the counter.
  - After exactly MPLIER_WIDTH cycles, go to FINISH.
- FINISH:
  - Negate the accumulator if sign=1.
  - Add the sign-extended addend at full MCAND_WIDTH+MPLIER_WIDTH+1 width.
  - Register result as the low MCAND_WIDTH bits.
  - Set overflow=1 when the full value differs from the sign-extension of its low MCAND_WIDTH bits.
  - Go to DONE.
- DONE: valid_out=1 for this one cycle, then return to IDLE.
- Latency: valid_out is high in the cycle following edge k+MPLIER_WIDTH+2, where k is the acceptance edge (34 cycles at the defaults). Throughput is one operation per MPLIER_WIDTH+3 cycles.
- valid_in while busy=1 is ignored and not queued. valid_in in the DONE cycle is also ignored.
- Operand inputs may change freely after the acceptance edge.
- result and overflow hold their values between valid_out pulses.
- Zero operands are not special-cased: the full iteration count still runs (unless the optional feature below is enabled).
- No division-by-zero analogue: every operand combination is legal.

Optional Feature:
- Macro MUL_ACC_EARLY_EXIT_EN.
- Defined: in CALC, when the remaining shifted multiplier equals 0, go to FINISH on that edge.
  - Latency becomes (index of the highest set bit of |multiplier|) + 4 cycles.
  - For multiplier=0 the latency is 3 cycles (CALC is entered once and exits immediately).
- Undefined: fixed MPLIER_WIDTH+2 latency, as specified above.
- result and overflow are identical with and without the macro.

Decomposition:
- Package mul_acc_pkg:
  - state_t enum {IDLE, CALC, FINISH, DONE} as logic [1:0].
  - Default width localparams.
  - An automatic abs function returning an unsigned magnitude.
- No sub-module: a single FSM with one datapath adder, in one module.

Test Plan:
- multiplicand=7, multiplier=-3, addend=2 -> result=-19, overflow=0; valid_out exactly 34 cycles after acceptance; busy high for 34 cycles.
- Divider round-trip: multiplicand=-5, multiplier=-4, addend=-1 -> result=19, overflow=0.
- multiplicand=2^62, multiplier=4, addend=0 -> result=0, overflow=1. Also multiplicand=-2^63, multiplier=1, addend=0 -> result=0x8000_0000_0000_0000, overflow=0.
- multiplicand=-2^63, multiplier=-1, addend=0 -> overflow=1, result=0x8000_0000_0000_0000. Also multiplier=0, addend=-9 -> result=-9; with MUL_ACC_EARLY_EXIT_EN, valid_out after 3 cycles.
- valid_in pulsed while busy with different operands -> ignored; the first result (100*3+0=300) is returned and only one valid_out is seen.
- Reset asserted mid-CALC -> busy=0 and result=0 immediately; no valid_out. A new op 1*1+1 after release -> result=2.
